// File: rtl/seq_mac.sv
// seq_mac: sequential multiply-accumulate.
//   A start accepted in IDLE captures X, Y and acc_clr. WIDTH radix-2 shift-add
//   iterations form P = X*Y. One further cycle loads P into the accumulator Z
//   (acc_clr=1) or adds P to it (acc_clr=0), and pulses valid.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, acc_clr  request and its load/accumulate select, sampled in IDLE
//   X, Y            operands, captured when start is accepted
//   busy            state != IDLE
//   valid           one-cycle pulse when P and Z update
//   P               product of the last completed operation (2*WIDTH bits)
//   Z               accumulator (ACC_WIDTH bits, wraps)
//   ovf             sticky accumulate overflow, cleared by a load or reset
module seq_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   acc_clr,
  input  logic [WIDTH-1:0]       X,
  input  logic [WIDTH-1:0]       Y,
  output logic                   busy,
  output logic                   valid,
  output logic [2*WIDTH-1:0]     P,
  output logic [ACC_WIDTH-1:0]   Z,
  output logic                   ovf
);
  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]        mcand;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]     mplier;  // multiplier, shifted right each iteration
  logic [PW-1:0]        prod;    // partial product
  logic [CW-1:0]        cnt;
  logic                 clr_q;

  logic                 last_it;
  logic [PW-1:0]        mcand_init, addend, prod_nxt;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 acc_ovf;

  assign last_it = (cnt == CW'(WIDTH-1));
  assign addend  = mplier[0] ? mcand : '0;
  assign busy    = (state != S_IDLE);

  // Signed mode: the MSB of Y has weight -2^(W-1), so the last iteration
  // subtracts. With X sign-extended to 2*WIDTH the result is exact modulo
  // 2^(2*WIDTH), including -2^(W-1) * -2^(W-1).
  always_comb begin
    mcand_init = PW'(X);
    ext        = ACC_WIDTH'(prod);
    prod_nxt   = prod + addend;
    if (SIGNED) begin
      mcand_init = PW'($signed(X));
      ext        = ACC_WIDTH'($signed(prod));
      if (last_it) prod_nxt = prod - addend;
    end
  end

  // One bit wider than Z so the unsigned carry-out is visible.
  always_comb begin
    sum = {1'b0, Z} + {1'b0, ext};
    if (SIGNED)
      acc_ovf = (Z[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != Z[ACC_WIDTH-1]);
    else
      acc_ovf = sum[ACC_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MUL;
      S_MUL:   if (last_it) state_nxt = S_ACC;
      S_ACC:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      clr_q  <= 1'b0;
      valid  <= 1'b0;
      P      <= '0;
      Z      <= '0;
      ovf    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mcand  <= mcand_init;
          mplier <= Y;
          prod   <= '0;
          cnt    <= '0;
          clr_q  <= acc_clr;
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_ACC: begin
          P     <= prod;
          valid <= 1'b1;
          if (clr_q) begin
            Z   <= ext;
            ovf <= 1'b0;
          end else begin
            Z   <= sum[ACC_WIDTH-1:0];
            ovf <= ovf | acc_ovf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mac.sv
module tb_seq_mac;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // unsigned instance
  logic        start_u, clr_u, busy_u, valid_u, ovf_u;
  logic [7:0]  x_u, y_u;
  logic [15:0] p_u;
  logic [19:0] z_u;
  // signed instance
  logic        start_s, clr_s, busy_s, valid_s, ovf_s;
  logic [7:0]  x_s, y_s;
  logic [15:0] p_s;
  logic [19:0] z_s;

  seq_mac #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start_u), .acc_clr(clr_u), .X(x_u), .Y(y_u),
    .busy(busy_u), .valid(valid_u), .P(p_u), .Z(z_u), .ovf(ovf_u));

  seq_mac #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst(rst), .start(start_s), .acc_clr(clr_s), .X(x_s), .Y(y_s),
    .busy(busy_s), .valid(valid_s), .P(p_s), .Z(z_s), .ovf(ovf_s));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Drive a request from the current time (away from an edge), let one edge
  // accept it, then drop start.
  task automatic launch(input bit s, input logic [7:0] x, input logic [7:0] y, input bit clr);
    if (s) begin x_s = x; y_s = y; clr_s = clr; start_s = 1'b1; end
    else   begin x_u = x; y_u = y; clr_u = clr; start_u = 1'b1; end
    @(posedge clk); #1;
    start_s = 1'b0; start_u = 1'b0;
  endtask

  // Wait for valid; lat counts edges after the accept edge, nb counts busy
  // cycles seen before valid. poke disturbs start/X/Y mid-operation.
  task automatic wait_done(input bit s, input bit poke, output int lat, output int nb);
    lat = 0; nb = 0;
    while (!(s ? valid_s : valid_u) && lat < 40) begin
      if (s ? busy_s : busy_u) nb++;
      if (poke && lat == 3) begin
        if (s) begin x_s = 8'd1; y_s = 8'd1; start_s = 1'b1; end
        else   begin x_u = 8'd1; y_u = 8'd1; start_u = 1'b1; end
      end
      if (poke && lat == 4) begin start_s = 1'b0; start_u = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    start_s = 1'b0; start_u = 1'b0;
  endtask

  task automatic op(input bit s, input logic [7:0] x, input logic [7:0] y, input bit clr,
                    input bit poke, output int lat, output int nb);
    @(negedge clk);
    launch(s, x, y, clr);
    wait_done(s, poke, lat, nb);
  endtask

  // After a valid cycle: no further valid or busy for n cycles.
  task automatic quiet(input string tag, input int n);
    int extra = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (valid_u || busy_u) extra++;
    end
    chk(tag, extra, 0);
  endtask

  initial begin
    int lat, nb;
    rst = 1'b1;
    start_u = 0; clr_u = 0; x_u = 0; y_u = 0;
    start_s = 0; clr_s = 0; x_s = 0; y_s = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy_u, valid_u, ovf_u, p_u, z_u[12:0]}, 0);
    chk("rst_z", z_u, 0);
    @(negedge clk); rst = 1'b0;

    // 1: load then accumulate
    op(0, 8'd12, 8'd11, 1'b1, 1'b0, lat, nb);
    chk("t1_lat", lat, 9);
    chk("t1_busy", nb, 9);
    chk("t1_busy_in_valid", busy_u, 0);
    chk("t1_p", p_u, 132);
    chk("t1_z", z_u, 132);
    chk("t1_ovf", ovf_u, 0);
    @(posedge clk); #1;
    chk("t1_valid_width", valid_u, 0);
    chk("t1_p_hold", p_u, 132);
    op(0, 8'd4, 8'd6, 1'b0, 1'b0, lat, nb);
    chk("t1b_p", p_u, 24);
    chk("t1b_z", z_u, 156);

    // 4: start (with X=Y=1) mid-operation is ignored
    op(0, 8'd12, 8'd11, 1'b1, 1'b1, lat, nb);
    chk("t4_lat", lat, 9);
    chk("t4_p", p_u, 132);
    chk("t4_z", z_u, 132);

    // 6: back-to-back start in the valid cycle; X/Y disturbed mid-op
    launch(0, 8'd2, 8'd3, 1'b0);
    wait_done(0, 1'b1, lat, nb);
    chk("t6_lat", lat, 9);
    chk("t6_p", p_u, 6);
    chk("t6_z", z_u, 138);
    quiet("t6_no_extra", 12);

    // 5: async reset mid-MUL
    @(negedge clk);
    launch(0, 8'd12, 8'd11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_before", busy_u, 1);
    rst = 1'b1; #1;
    chk("t5_busy", busy_u, 0);
    chk("t5_valid", valid_u, 0);
    chk("t5_p", p_u, 0);
    chk("t5_z", z_u, 0);
    chk("t5_ovf", ovf_u, 0);
    @(negedge clk); rst = 1'b0;
    quiet("t5_no_valid", 12);
    op(0, 8'd3, 8'd3, 1'b0, 1'b0, lat, nb);
    chk("t5_p9", p_u, 9);
    chk("t5_z9", z_u, 9);

    // 2: overflow, stickiness, clear
    op(0, 8'd255, 8'd255, 1'b1, 1'b0, lat, nb);
    chk("t2_p", p_u, 65025);
    for (int i = 0; i < 15; i++) op(0, 8'd255, 8'd255, 1'b0, 1'b0, lat, nb);
    chk("t2_z16", z_u, 1040400);
    chk("t2_ovf16", ovf_u, 0);
    op(0, 8'd255, 8'd255, 1'b0, 1'b0, lat, nb);
    chk("t2_z17", z_u, 56849);
    chk("t2_ovf17", ovf_u, 1);
    op(0, 8'd1, 8'd1, 1'b0, 1'b0, lat, nb);
    chk("t2_z_wrap_acc", z_u, 56850);
    chk("t2_ovf_sticky", ovf_u, 1);
    op(0, 8'd1, 8'd1, 1'b1, 1'b0, lat, nb);
    chk("t2_z_clr", z_u, 1);
    chk("t2_ovf_clr", ovf_u, 0);

    // 3: signed
    op(1, 8'hFB, 8'd7, 1'b1, 1'b0, lat, nb);
    chk("t3_lat", lat, 9);
    chk("t3_p", p_s, 32'h0000FFDD);
    chk("t3_z", z_s, 32'h000FFFDD);
    op(1, 8'h80, 8'h80, 1'b0, 1'b0, lat, nb);
    chk("t3_p_min", p_s, 16384);
    chk("t3_z2", z_s, 16349);
    chk("t3_ovf", ovf_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
